ahb_lite_master: RTL

Command-driven AHB-Lite initiator. It sits at the opposite end of the bus from the AHB-Lite memory slave. It accepts SINGLE and INCR4 transfer commands on a valid/ready port and drives pipelined address and data phases on the AHB-Lite bus. It honours HREADY wait states and the two-cycle HRESP error, and returns one response per beat. It is used as the active bus driver in the memory test environment and as a reusable initiator in system builds.

---
 rtl/ahb_lite_master.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/ahb_lite_master.sv
// Command-driven AHB-Lite initiator: SINGLE/INCR4 commands in, pipelined address/data phases out.
// One response per completed data phase; ERROR cancels the rest of the burst and yields one final error response.
module ahb_lite_master #(
  parameter int          ADDR_W    = 32,
  parameter int          DATA_W    = 32,
  parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic              cmd_write,
  input  logic [2:0]        cmd_size,
  input  logic              cmd_incr4,
  input  logic              wd_valid,
  output logic              wd_ready,
  input  logic [DATA_W-1:0] wd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_last,
  output logic [ADDR_W-1:0] HADDR,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [3:0]        HPROT,
  output logic [1:0]        HTRANS,
  output logic [DATA_W-1:0] HWDATA,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HREADY,
  input  logic              HRESP
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_ERR1} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   haddr_q, haddr_d;
  logic                hwrite_q, hwrite_d;
  logic [2:0]          hsize_q, hsize_d;
  logic [2:0]          hburst_q, hburst_d;
  logic [DATA_W-1:0]   hwdata_q, hwdata_d;
  logic                ap_vld_q, ap_vld_d;
  logic                ap_first_q, ap_first_d;
  logic [1:0]          beats_q, beats_d;
  logic                dp_vld_q, dp_vld_d;
  logic                dp_write_q, dp_write_d;
  logic                dp_last_q, dp_last_d;

  logic ap_go, addr_done, last_addr, dp_done, err_start, accept, load;

  // a pending write beat is only a real transfer once its data is offered
  assign ap_go     = ap_vld_q && (state_q != S_ERR1) && (!hwrite_q || wd_valid);
  assign addr_done = ap_go && HREADY;
  assign last_addr = addr_done && (beats_q == 2'd0);
  assign dp_done   = dp_vld_q && HREADY;
  assign err_start = dp_vld_q && HRESP && !HREADY;
  assign accept    = cmd_valid && cmd_ready;

  // also ready while the final address phase completes, so the next NONSEQ overlaps the last data phase
  assign cmd_ready = !HRESET && ((state_q == S_IDLE) || ((state_q == S_DATA) && HREADY) ||
                                 ((state_q == S_ADDR) && last_addr));
  assign wd_ready  = !HRESET && addr_done && hwrite_q;
  assign rsp_valid = !HRESET && (dp_done || ((state_q == S_ERR1) && HREADY));
  assign rsp_err   = rsp_valid && (state_q == S_ERR1);
  assign rsp_last  = rsp_valid && ((state_q == S_ERR1) || dp_last_q);
  assign rsp_rdata = (rsp_valid && (state_q != S_ERR1) && !dp_write_q) ? HRDATA : '0;

  assign HADDR  = haddr_q;
  assign HWRITE = hwrite_q;
  assign HSIZE  = hsize_q;
  assign HBURST = hburst_q;
  assign HPROT  = HPROT_VAL;
  assign HWDATA = hwdata_q;

  always_comb begin
    HTRANS = 2'b00;
    if (ap_vld_q && (state_q != S_ERR1)) begin
      if (ap_go) HTRANS = ap_first_q ? 2'b10 : 2'b11;
      else       HTRANS = ap_first_q ? 2'b00 : 2'b01;
    end
  end

  always_comb begin
    state_d    = state_q;
    haddr_d    = haddr_q;
    hwrite_d   = hwrite_q;
    hsize_d    = hsize_q;
    hburst_d   = hburst_q;
    hwdata_d   = hwdata_q;
    ap_vld_d   = ap_vld_q;
    ap_first_d = ap_first_q;
    beats_d    = beats_q;
    dp_vld_d   = dp_vld_q;
    dp_write_d = dp_write_q;
    dp_last_d  = dp_last_q;
    load       = 1'b0;
    case (state_q)
      S_IDLE: if (accept) load = 1'b1;
      S_ADDR: begin
        if (err_start) begin
          state_d  = S_ERR1;
          dp_vld_d = 1'b0;
          // a pending address belonging to the next command survives the error
          if (!dp_last_q) ap_vld_d = 1'b0;
        end else begin
          if (dp_done) dp_vld_d = 1'b0;
          if (addr_done) begin
            dp_vld_d   = 1'b1;
            dp_write_d = hwrite_q;
            dp_last_d  = (beats_q == 2'd0);
            if (hwrite_q) hwdata_d = wd_data;
            if (beats_q != 2'd0) begin
              haddr_d    = haddr_q + (ADDR_W'(1) << hsize_q);
              beats_d    = beats_q - 2'd1;
              ap_first_d = 1'b0;
            end else if (accept) begin
              load = 1'b1;
            end else begin
              ap_vld_d = 1'b0;
              state_d  = S_DATA;
            end
          end
        end
      end
      S_DATA: begin
        if (err_start) begin
          state_d  = S_ERR1;
          dp_vld_d = 1'b0;
        end else if (HREADY) begin
          dp_vld_d = 1'b0;
          if (accept) load = 1'b1;
          else        state_d = S_IDLE;
        end
      end
      S_ERR1: if (HREADY) state_d = ap_vld_q ? S_ADDR : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (load) begin
      state_d    = S_ADDR;
      haddr_d    = cmd_addr;
      hwrite_d   = cmd_write;
      hsize_d    = (cmd_size > 3'd2) ? 3'd2 : cmd_size;
      hburst_d   = cmd_incr4 ? 3'b011 : 3'b000;
      beats_d    = cmd_incr4 ? 2'd3 : 2'd0;
      ap_vld_d   = 1'b1;
      ap_first_d = 1'b1;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q    <= S_IDLE;
      haddr_q    <= '0;
      hwrite_q   <= 1'b0;
      hsize_q    <= 3'd0;
      hburst_q   <= 3'd0;
      hwdata_q   <= '0;
      ap_vld_q   <= 1'b0;
      ap_first_q <= 1'b0;
      beats_q    <= 2'd0;
      dp_vld_q   <= 1'b0;
      dp_write_q <= 1'b0;
      dp_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      haddr_q    <= haddr_d;
      hwrite_q   <= hwrite_d;
      hsize_q    <= hsize_d;
      hburst_q   <= hburst_d;
      hwdata_q   <= hwdata_d;
      ap_vld_q   <= ap_vld_d;
      ap_first_q <= ap_first_d;
      beats_q    <= beats_d;
      dp_vld_q   <= dp_vld_d;
      dp_write_q <= dp_write_d;
      dp_last_q  <= dp_last_d;
    end
  end

endmodule
